rv32i_ctrl_fsm: RTL and testbench
=================================

Name: rv32i_ctrl_fsm

Overview:
- Multi-cycle sequencer for the RV32I core: steps each instruction through FETCH, DECODE, EXECUTE, optional MEM, and WB.
- Drives instruction-register, register-file, PC and data-memory strobes around the combinational decoder and ALU.
- Uses req/ack handshakes to instruction and data memory, with a bus timeout.
- Keeps a retired-instruction counter; reports halt (ECALL/EBREAK) and fault (illegal opcode, bus timeout).

Parameters:
TIMEOUT_CYCLES, 16, cycles a req may stay unacknowledged before FAULT; 0 disables timeout
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
ir_opcode  in  7  opcode field of latched instruction register
dec_halt  in  1  decoder halt flag (ECALL/EBREAK)
branch_taken  in  1  ALU branch compare result, valid in EXECUTE
imem_ack  in  1  instruction memory ack; rdata valid same cycle
dmem_ack  in  1  data memory ack
imem_req  out  1  instruction fetch request
ir_we  out  1  load instruction register
pc_we  out  1  update PC
pc_sel  out  2  00 pc+4, 01 pc+imm (taken branch/JAL), 10 ALU result (JALR)
rf_we  out  1  register-file write enable
wb_sel  out  2  00 ALU, 01 load data, 10 pc+4
dmem_req  out  1  data memory request
dmem_we  out  1  1 store, 0 load; valid while dmem_req
halted  out  1  core halted
fault  out  1  core faulted
instret  out  INSTRET_W  retired-instruction count
state_o  out  3  current state, for debug

Behaviour:
- States: RESET=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7. Outputs are Moore, decoded from state plus latched opcode class.
- Async reset: state=RESET, instret=0, wait counter=0. All outputs are 0 in RESET. State moves to FETCH on the first clk edge after rst_n deasserts. Reset mid-operation aborts immediately; no partial strobes.
- FETCH: imem_req=1 until imem_ack. In the ack cycle, ir_we=1 and next state is DECODE. Minimum 1 cycle.
- DECODE (1 cycle): latch opcode class.
  - dec_halt=1 or opcode 1110011 -> HALT.
  - Opcode not in {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111} -> FAULT.
  - Otherwise -> EXEC.
- EXEC (1 cycle): load (0000011) or store (0100011) -> MEM; all others -> WB. branch_taken is sampled here and registered for WB.
- MEM: dmem_req=1 and dmem_we=(store) until dmem_ack, then -> WB.
- WB (1 cycle): pc_we=1, instret+=1 (wraps modulo 2^INSTRET_W), then -> FETCH.
  - pc_sel: JAL 01, JALR 10, branch 01 if taken else 00, others 00.
  - rf_we: 1 for LUI, AUIPC, JAL, JALR, load, OP-IMM, OP; 0 for branch, store, FENCE.
  - wb_sel: load 01, JAL/JALR 10, else 00.
- Latency with zero-wait ack: 4 cycles for non-memory instructions, 5 for load/store.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle req=1 without ack.
  - On reaching TIMEOUT_CYCLES -> FAULT.
  - If ack and terminal count coincide, ack wins.
- Acks outside their req window are ignored.
- HALT: halted=1. FAULT: fault=1. Both are sticky until reset, with all strobes 0 and instret frozen.
- Exactly one pc_we pulse and one instret increment per retired instruction.

Decomposition:
- Package rv32i_ctrl_pkg holds:
  - opcode localparams;
  - state encoding;
  - pc_sel and wb_sel encodings;
  - opcode-class enum: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM.
- Sub-module bus_wait_timer (clear, count_en, terminal flag), shared by the FETCH and MEM waits.

Test Plan:
- Reset release, imem_ack tied 1, ADDI (0010011) -> states 1,2,3,5; rf_we=1, wb_sel=00, pc_sel=00 in cycle 4; instret=1.
- LW (0000011) with dmem_ack delayed 3 cycles -> dmem_req=1 and dmem_we=0 for 4 cycles; WB with wb_sel=01; 8 cycles from fetch start.
- BEQ with branch_taken=1, then BEQ with branch_taken=0 -> WB pc_sel=01 then 00; rf_we=0 both; instret=2.
- imem_ack held 0, TIMEOUT_CYCLES=16 -> fault=1 after 16 req cycles, state_o=7. Repeat with ack on cycle 16 -> no fault.
- ECALL (1110011) -> halted=1, no pc_we, instret unchanged. Illegal opcode 1111111 -> fault=1.
- Assert rst_n low during MEM of SW -> dmem_req drops asynchronously; state RESET; instret=0; FETCH one cycle after release.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// rv32i_ctrl_pkg: opcodes, state/select encodings and opcode classification for the control FSM
package rv32i_ctrl_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;
  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_LOAD  = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;
  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD,
    CLS_STORE, CLS_OPIMM, CLS_OP, CLS_FENCE, CLS_SYSTEM
  } opc_class_t;
  function automatic logic is_legal(input logic [6:0] opc);
    return opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                       OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE};
  endfunction
  function automatic opc_class_t classify(input logic [6:0] opc);
    case (opc)
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_OPIMM:  return CLS_OPIMM;
      OPC_FENCE:  return CLS_FENCE;
      OPC_SYSTEM: return CLS_SYSTEM;
      default:    return CLS_OP;
    endcase
  endfunction
endpackage

// File: rtl/rv32i_ctrl_fsm_if.sv
// rv32i_ctrl_fsm_if: decoder/ALU/memory-facing signals of the control sequencer
interface rv32i_ctrl_fsm_if #(parameter int INSTRET_W = 32);
  logic [6:0]           ir_opcode;
  logic                 dec_halt;
  logic                 branch_taken;
  logic                 imem_ack;
  logic                 dmem_ack;
  logic                 imem_req;
  logic                 ir_we;
  logic                 pc_we;
  logic [1:0]           pc_sel;
  logic                 rf_we;
  logic [1:0]           wb_sel;
  logic                 dmem_req;
  logic                 dmem_we;
  logic                 halted;
  logic                 fault;
  logic [INSTRET_W-1:0] instret;
  logic [2:0]           state_o;
  modport master (
    input  ir_opcode, dec_halt, branch_taken, imem_ack, dmem_ack,
    output imem_req, ir_we, pc_we, pc_sel, rf_we, wb_sel, dmem_req, dmem_we,
           halted, fault, instret, state_o
  );
  modport slave (
    output ir_opcode, dec_halt, branch_taken, imem_ack, dmem_ack,
    input  imem_req, ir_we, pc_we, pc_sel, rf_we, wb_sel, dmem_req, dmem_we,
           halted, fault, instret, state_o
  );
endinterface

// File: rtl/rv32i_ctrl_fsm_bus_wait_timer.sv
// bus_wait_timer: counts unacknowledged request cycles; terminal flags the last allowed wait cycle
module bus_wait_timer #(parameter int unsigned TIMEOUT_CYCLES = 16) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic terminal
);
  localparam int unsigned W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : count_en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign terminal = (TIMEOUT_CYCLES != 0) && count_en && (cnt_q == LAST);
endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// rv32i_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with bus timeout, halt and fault
module rv32i_ctrl_fsm
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int          INSTRET_W      = 32
) (
  input logic             clk,
  input logic             rst_n,
  rv32i_ctrl_fsm_if.master bus
);
  state_t               state_q, state_d;
  opc_class_t           cls_q, cls_d;
  logic                 taken_q, taken_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 wait_en, wait_clr, tmo;
  logic                 wb;
  assign wait_en  = (state_q == S_FETCH && !bus.imem_ack) || (state_q == S_MEM && !bus.dmem_ack);
  assign wait_clr = (state_d == S_FETCH && state_q != S_FETCH) || (state_d == S_MEM && state_q != S_MEM);
  bus_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .rst_n(rst_n), .clear(wait_clr), .count_en(wait_en), .terminal(tmo)
  );
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    taken_d   = taken_q;
    instret_d = state_q == S_WB ? instret_q + 1'b1 : instret_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = bus.imem_ack ? S_DECODE : tmo ? S_FAULT : S_FETCH;
      S_DECODE: begin
        cls_d   = classify(bus.ir_opcode);
        state_d = (bus.dec_halt || bus.ir_opcode == OPC_SYSTEM) ? S_HALT
                : is_legal(bus.ir_opcode) ? S_EXEC : S_FAULT;
      end
      S_EXEC: begin
        taken_d = bus.branch_taken;
        state_d = (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? S_MEM : S_WB;
      end
      S_MEM:    state_d = bus.dmem_ack ? S_WB : tmo ? S_FAULT : S_MEM;
      S_WB:     state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_RESET;
      cls_q     <= CLS_OP;
      taken_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      taken_q   <= taken_d;
      instret_q <= instret_d;
    end
  assign wb           = state_q == S_WB;
  assign bus.imem_req = state_q == S_FETCH;
  assign bus.ir_we    = bus.imem_req && bus.imem_ack;
  assign bus.dmem_req = state_q == S_MEM;
  assign bus.dmem_we  = bus.dmem_req && cls_q == CLS_STORE;
  assign bus.pc_we    = wb;
  assign bus.rf_we    = wb && !(cls_q inside {CLS_BRANCH, CLS_STORE, CLS_FENCE});
  assign bus.pc_sel   = !wb ? PC_PLUS4
                      : cls_q == CLS_JAL ? PC_IMM
                      : cls_q == CLS_JALR ? PC_ALU
                      : (cls_q == CLS_BRANCH && taken_q) ? PC_IMM : PC_PLUS4;
  assign bus.wb_sel   = !wb ? WB_ALU
                      : cls_q == CLS_LOAD ? WB_LOAD
                      : (cls_q == CLS_JAL || cls_q == CLS_JALR) ? WB_PC4 : WB_ALU;
  assign bus.halted   = state_q == S_HALT;
  assign bus.fault    = state_q == S_FAULT;
  assign bus.instret  = instret_q;
  assign bus.state_o  = state_q;
endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// tb_rv32i_ctrl_fsm: directed sequence; expected write-back strobes are queued at fetch and checked on pc_we
module tb_rv32i_ctrl_fsm;
  typedef struct packed {
    logic [1:0]  psel;
    logic        rfw;
    logic [1:0]  wsel;
    logic [31:0] ir;
  } wb_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_instret = 0;
  wb_t q[$];
  rv32i_ctrl_fsm_if #(.INSTRET_W(32)) bus_if ();
  rv32i_ctrl_fsm #(.TIMEOUT_CYCLES(16), .INSTRET_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    wb_t e;
    if (rst_n === 1'b1 && bus_if.pc_we === 1'b1) begin
      chk("wb_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wb_pc_sel", 32'(bus_if.pc_sel), 32'(e.psel));
        chk("wb_rf_we", 32'(bus_if.rf_we), 32'(e.rfw));
        chk("wb_wb_sel", 32'(bus_if.wb_sel), 32'(e.wsel));
        chk("wb_instret", bus_if.instret, e.ir);
      end
    end
  end
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_state", 32'(bus_if.state_o), 32'd0);
    chk("rst_strobes", {bus_if.imem_req, bus_if.ir_we, bus_if.pc_we, bus_if.rf_we, bus_if.dmem_req,
                        bus_if.dmem_we, bus_if.halted, bus_if.fault, bus_if.pc_sel, bus_if.wb_sel}, 32'd0);
    chk("rst_instret", bus_if.instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_to_fetch", 32'(bus_if.state_o), 32'd1);
    exp_instret = 0;
  endtask
  task automatic exec_instr(input logic [6:0] opc, input logic taken, input int mem_wait,
                            input logic [1:0] psel, input logic rfw, input logic [1:0] wsel);
    int t0;
    logic is_mem;
    is_mem = (opc == 7'b0000011) || (opc == 7'b0100011);
    bus_if.ir_opcode = opc;
    bus_if.imem_ack = 1'b1;
    bus_if.dmem_ack = 1'b0;
    #1;
    chk("fetch_state", 32'(bus_if.state_o), 32'd1);
    chk("fetch_req_irwe", {bus_if.imem_req, bus_if.ir_we}, 32'd3);
    q.push_back('{psel, rfw, wsel, 32'(exp_instret)});
    t0 = cyc;
    tick();
    chk("decode_state", 32'(bus_if.state_o), 32'd2);
    tick();
    chk("exec_state", 32'(bus_if.state_o), 32'd3);
    bus_if.ir_opcode = 7'h7f;
    bus_if.branch_taken = taken;
    tick();
    if (is_mem) begin
      for (int i = 0; i <= mem_wait; i++) begin
        chk("mem_state", 32'(bus_if.state_o), 32'd4);
        chk("mem_req_we", {bus_if.dmem_req, bus_if.dmem_we}, {30'd0, 1'b1, opc == 7'b0100011});
        bus_if.dmem_ack = (i == mem_wait);
        tick();
      end
      bus_if.dmem_ack = 1'b0;
    end
    bus_if.branch_taken = ~taken;
    chk("wb_state", 32'(bus_if.state_o), 32'd5);
    chk("wb_pc_we", 32'(bus_if.pc_we), 32'd1);
    tick();
    exp_instret++;
    chk("retire_state", 32'(bus_if.state_o), 32'd1);
    chk("retire_pc_we", 32'(bus_if.pc_we), 32'd0);
    chk("retire_instret", bus_if.instret, 32'(exp_instret));
    chk("latency", 32'(cyc - t0), is_mem ? 32'(5 + mem_wait) : 32'd4);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bus_if.ir_opcode = 7'b0010011;
    bus_if.dec_halt = 1'b0;
    bus_if.branch_taken = 1'b0;
    bus_if.imem_ack = 1'b0;
    bus_if.dmem_ack = 1'b1;
    do_reset();
    exec_instr(7'b0010011, 1'b0, 0, 2'b00, 1'b1, 2'b00);
    exec_instr(7'b0000011, 1'b0, 3, 2'b00, 1'b1, 2'b01);
    exec_instr(7'b1100011, 1'b1, 0, 2'b01, 1'b0, 2'b00);
    exec_instr(7'b1100011, 1'b0, 0, 2'b00, 1'b0, 2'b00);
    exec_instr(7'b1101111, 1'b0, 0, 2'b01, 1'b1, 2'b10);
    exec_instr(7'b1100111, 1'b1, 0, 2'b10, 1'b1, 2'b10);
    exec_instr(7'b0100011, 1'b0, 0, 2'b00, 1'b0, 2'b00);
    exec_instr(7'b0110111, 1'b0, 0, 2'b00, 1'b1, 2'b00);
    exec_instr(7'b0001111, 1'b1, 0, 2'b00, 1'b0, 2'b00);
    exec_instr(7'b0110011, 1'b0, 0, 2'b00, 1'b1, 2'b00);
    bus_if.imem_ack = 1'b0;
    bus_if.dmem_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("tmo_wait", {bus_if.state_o, bus_if.imem_req, bus_if.ir_we}, {27'd0, 3'd1, 2'b10});
      tick();
    end
    chk("tmo_state", 32'(bus_if.state_o), 32'd7);
    chk("tmo_fault", {bus_if.fault, bus_if.imem_req, bus_if.halted}, 32'b100);
    bus_if.imem_ack = 1'b1;
    tick();
    tick();
    chk("fault_sticky", {bus_if.state_o, bus_if.fault, bus_if.imem_req, bus_if.pc_we}, {26'd0, 3'd7, 3'b100});
    chk("fault_instret", bus_if.instret, 32'(exp_instret));
    do_reset();
    bus_if.imem_ack = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    exec_instr(7'b0010011, 1'b0, 0, 2'b00, 1'b1, 2'b00);
    bus_if.ir_opcode = 7'b1110011;
    bus_if.imem_ack = 1'b1;
    tick();
    tick();
    chk("ecall_state", 32'(bus_if.state_o), 32'd6);
    chk("ecall_halted", {bus_if.halted, bus_if.fault, bus_if.pc_we, bus_if.imem_req}, 32'b1000);
    tick();
    tick();
    chk("halt_sticky", {bus_if.state_o, bus_if.halted}, {28'd0, 3'd6, 1'b1});
    chk("halt_instret", bus_if.instret, 32'd1);
    do_reset();
    bus_if.ir_opcode = 7'b0010011;
    bus_if.dec_halt = 1'b1;
    tick();
    tick();
    chk("dec_halt_state", 32'(bus_if.state_o), 32'd6);
    bus_if.dec_halt = 1'b0;
    do_reset();
    bus_if.ir_opcode = 7'b1111111;
    tick();
    tick();
    chk("illegal_state", 32'(bus_if.state_o), 32'd7);
    chk("illegal_fault", {bus_if.fault, bus_if.halted, bus_if.pc_we}, 32'b100);
    do_reset();
    exec_instr(7'b0010011, 1'b0, 0, 2'b00, 1'b1, 2'b00);
    bus_if.ir_opcode = 7'b0100011;
    tick();
    tick();
    tick();
    chk("sw_mem", {bus_if.state_o, bus_if.dmem_req, bus_if.dmem_we}, {27'd0, 3'd4, 2'b11});
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {bus_if.dmem_req, bus_if.dmem_we, bus_if.pc_we}, 32'd0);
    chk("async_rst_state", 32'(bus_if.state_o), 32'd0);
    chk("async_rst_instret", bus_if.instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("async_rst_fetch", 32'(bus_if.state_o), 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
